dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp
// Purpose  : Data-memory responder for a simple core. It accepts one request
//            (read or write) in IDLE, waits WAIT_CYCLES wait states, then
//            presents a response beat that is held until the core consumes it.
//            Misaligned or out-of-range beats return rsp_err=1 with zero data
//            and never modify memory.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-low reset
//            req_valid  / req_ready  - request handshake (ready only in IDLE)
//            req_we     - 1 = write, 0 = read
//            req_addr   - byte address
//            req_wdata  - store data
//            req_burst  - 5-word vector read (only with DMEM_BURST_EN)
//            rsp_valid  / rsp_ready  - response handshake
//            rsp_rdata  - load data (0 for writes and faulted beats)
//            rsp_err    - faulted beat
// Config   : DMEM_BURST_EN - when defined, burst reads return 5 beats at
//            addr, addr+4 .. addr+16 and burst writes fault. When undefined
//            req_burst is ignored and no beat counter exists.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_burst,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_aw        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam bit         c_no_wait   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_live;        // low until the first edge after reset release
    logic [31:0]   r_addr;        // address of the current beat
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wcnt;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          w_accept;
    logic [31:0]   w_cur_addr;
    logic          w_cur_we;
    logic [31:0]   w_cur_wdata;
    logic          w_bad;
    logic          w_err;
    logic          w_last;
    logic          w_commit;
    logic [c_aw-1:0] w_index;

    // In IDLE the request is still on the inputs (needed when WAIT_CYCLES=0
    // commits a write on the acceptance edge); otherwise use latched copies.
    assign w_accept    = req_valid && req_ready;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_index     = w_cur_addr[c_aw+1:2];
    assign w_bad       = (w_cur_addr[1:0] != 2'b00) || (w_cur_addr[31:c_aw+2] != '0);

`ifdef DMEM_BURST_EN
    logic       r_burst;
    logic [2:0] r_beat;
    logic       w_cur_burst;

    assign w_cur_burst = (r_state == IDLE) ? req_burst : r_burst;
    // A burst write is not supported: it becomes one faulted beat.
    assign w_err  = w_bad || (w_cur_we && w_cur_burst);
    assign w_last = !r_burst || r_we || (r_beat == 3'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_burst <= 1'b0;
            r_beat  <= 3'd0;
        end else if (w_accept) begin
            r_burst <= req_burst;
            r_beat  <= 3'd0;
        end else if (r_state == RESP && rsp_ready && !w_last) begin
            r_beat  <= r_beat + 3'd1;
        end
    end
`else
    logic w_unused_burst;
    assign w_unused_burst = req_burst;
    assign w_err  = w_bad;
    assign w_last = 1'b1;
`endif

    // Next-state and write-commit decode
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (c_no_wait) begin
                        w_next   = RESP;
                        w_commit = w_cur_we && !w_err;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next   = RESP;
                    w_commit = w_cur_we && !w_err;
                end
            end
            RESP: begin
                if (rsp_ready && w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_wcnt  <= c_wait_load;
            end else begin
                if (r_state == WAIT && r_wcnt != 4'd0) begin
                    r_wcnt <= r_wcnt - 4'd1;
                end
                if (r_state == RESP && rsp_ready && !w_last) begin
                    r_addr <= r_addr + 32'd4;
                end
            end
        end
    end

    // Storage has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            mem[w_index] <= w_cur_wdata;
        end
    end

    // Read data comes straight from the array; memory only changes on entry
    // to RESP, so the beat stays stable under backpressure.
    assign req_ready = r_live && (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = rsp_valid && w_err;
    assign rsp_rdata = (rsp_valid && !w_err && !r_we) ? mem[w_index] : 32'd0;

endmodule
`default_nettype wire
